// File: rtl/alu_seq_exec.sv
// Execute stage between register-file reads and write-back: single-cycle simple ops,
// iterative shifts and (with macro ALU_MUL_EN) an iterative shift-add multiplier.
module alu_seq_exec #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [2:0]        ALUOP,
  input  logic [WIDTH-1:0]  DATA1,
  input  logic [WIDTH-1:0]  DATA2,
  input  logic [ADDR_W-1:0] DESTADDR,
  output logic              BUSY,
  output logic [WIDTH-1:0]  RESULT,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic              ZERO
);

  localparam int unsigned     CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   ITERS  = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MAX_SH = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, WB} state_e;
  typedef enum logic [2:0] {
    OP_FWD = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_SUB = 3'b100, OP_MUL = 3'b101, OP_SLL = 3'b110, OP_SRA = 3'b111
  } op_e;

  state_e            state, next_state;
  op_e               op_q;
  logic [WIDTH-1:0]  acc;
  logic [CW-1:0]     cnt, term_q, start_shamt, cnt_nxt;
  logic              wb_en;
  logic              needs_iter, writes;
  logic [WIDTH-1:0]  imm_res, step_res;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]  mcand, mplier;
`endif

  always_comb begin
    start_shamt = (DATA2 >= MAX_SH) ? ITERS : DATA2[CW-1:0];
    needs_iter  = ((ALUOP == OP_SLL) || (ALUOP == OP_SRA)) && (start_shamt != '0);
`ifdef ALU_MUL_EN
    needs_iter  = needs_iter || (ALUOP == OP_MUL);
    writes      = 1'b1;
`else
    writes      = (ALUOP != OP_MUL);
`endif
    cnt_nxt     = cnt + CW'(1);
  end

  // Shifts with a zero count fall into the default arm and forward DATA1.
  always_comb begin
    imm_res = DATA1;
    case (op_e'(ALUOP))
      OP_FWD:  imm_res = DATA2;
      OP_ADD:  imm_res = DATA1 + DATA2;
      OP_AND:  imm_res = DATA1 & DATA2;
      OP_OR:   imm_res = DATA1 | DATA2;
      OP_SUB:  imm_res = DATA1 - DATA2;
      default: imm_res = DATA1;
    endcase
  end

  always_comb begin
    step_res = acc;
    case (op_q)
      OP_SLL:  step_res = acc << 1;
      OP_SRA:  step_res = {acc[WIDTH-1], acc[WIDTH-1:1]};
`ifdef ALU_MUL_EN
      OP_MUL:  step_res = mplier[0] ? (acc + mcand) : acc;
`endif
      default: step_res = acc;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (START) next_state = needs_iter ? ITER : WB;
      ITER:    if (cnt_nxt == term_q) next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_q      <= OP_FWD;
      acc       <= '0;
      cnt       <= '0;
      term_q    <= '0;
      wb_en     <= 1'b0;
      INADDRESS <= '0;
      RESULT    <= '0;
      ZERO      <= 1'b0;
`ifdef ALU_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (START) begin
          op_q      <= op_e'(ALUOP);
          acc       <= (ALUOP == OP_MUL) ? '0 : DATA1;
          cnt       <= '0;
          term_q    <= (ALUOP == OP_MUL) ? ITERS : start_shamt;
          wb_en     <= writes;
          INADDRESS <= DESTADDR;
`ifdef ALU_MUL_EN
          mcand     <= DATA1;
          mplier    <= DATA2;
`endif
          if (!needs_iter && writes) begin
            RESULT <= imm_res;
            ZERO   <= (imm_res == '0);
          end
        end
        ITER: begin
          acc <= step_res;
          cnt <= cnt_nxt;
`ifdef ALU_MUL_EN
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
`endif
          if (cnt_nxt == term_q) begin
            RESULT <= step_res;
            ZERO   <= (step_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY  = (state != IDLE);
  assign WRITE = (state == WB) && wb_en;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed-vector bench for alu_seq_exec; adapts the multiply checks to ALU_MUL_EN.
module tb_alu_seq_exec;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic [2:0] ALUOP = '0;
  logic [7:0] DATA1 = '0;
  logic [7:0] DATA2 = '0;
  logic [2:0] DESTADDR = '0;
  logic       BUSY, WRITE, ZERO;
  logic [7:0] RESULT;
  logic [2:0] INADDRESS;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq_exec #(.WIDTH(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ALUOP(ALUOP),
    .DATA1(DATA1), .DATA2(DATA2), .DESTADDR(DESTADDR),
    .BUSY(BUSY), .RESULT(RESULT), .WRITE(WRITE),
    .INADDRESS(INADDRESS), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit into cycle N+1 after accept edge N.
  task automatic issue(input logic [2:0] op, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [2:0] dst);
    @(negedge CLK);
    ALUOP = op; DATA1 = d1; DATA2 = d2; DESTADDR = dst; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [2:0] dst,
                        input int exp_lat, input logic [7:0] exp_res);
    int lat;
    issue(op, d1, d2, dst);
    lat = 1;
    while (!WRITE && lat < 20) begin
      check({tag, "_busy_iter"}, BUSY, 1'b1);
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, RESULT, exp_res);
    check({tag, "_addr"}, INADDRESS, dst);
    check({tag, "_zero"}, ZERO, exp_res == 8'h00);
    check({tag, "_busy_wb"}, BUSY, 1'b1);
    @(posedge CLK); #1;
    check({tag, "_busy_done"}, BUSY, 1'b0);
    check({tag, "_write_done"}, WRITE, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic saw_write;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", BUSY, 1'b0);
    check("rst_result", RESULT, 8'h00);
    check("rst_write", WRITE, 1'b0);
    check("rst_addr", INADDRESS, 3'd0);
    check("rst_zero", ZERO, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;

    run_op("add", 3'b001, 8'h05, 8'h07, 3'd3, 1, 8'h0C);
    run_op("sub_eq", 3'b100, 8'h05, 8'h05, 3'd1, 1, 8'h00);
    run_op("sub_neg", 3'b100, 8'h03, 8'h05, 3'd2, 1, 8'hFE);

`ifdef ALU_MUL_EN
    issue(3'b101, 8'h0D, 8'h0B, 3'd6);
    for (int i = 1; i <= 8; i++) begin
      check("mul_busy", BUSY, 1'b1);
      check("mul_nowrite", WRITE, 1'b0);
      @(negedge CLK);
      DATA1 = 8'($urandom); DATA2 = 8'($urandom); ALUOP = 3'b001; START = 1'b1;
      @(posedge CLK); #1;
    end
    check("mul_write", WRITE, 1'b1);
    check("mul_res", RESULT, 8'h8F);
    check("mul_addr", INADDRESS, 3'd6);
    check("mul_zero", ZERO, 1'b0);
    @(posedge CLK); #1;
    START = 1'b0;
    check("mul_busy_done", BUSY, 1'b0);
    check("mul_write_done", WRITE, 1'b0);
    @(posedge CLK); #1;
    check("mul_no_requeue", BUSY, 1'b0);
    check("mul_hold", RESULT, 8'h8F);
`else
    issue(3'b101, 8'h02, 8'h03, 3'd4);
    check("mul_off_busy", BUSY, 1'b1);
    check("mul_off_write", WRITE, 1'b0);
    check("mul_off_res", RESULT, 8'hFE);
    check("mul_off_zero", ZERO, 1'b0);
    @(posedge CLK); #1;
    check("mul_off_busy_done", BUSY, 1'b0);
    check("mul_off_write_done", WRITE, 1'b0);
    check("mul_off_hold", RESULT, 8'hFE);
`endif

    run_op("sra2", 3'b111, 8'h90, 8'h02, 3'd5, 3, 8'hE4);
    run_op("sll0", 3'b110, 8'h81, 8'h00, 3'd7, 1, 8'h81);
    run_op("sll_sat", 3'b110, 8'hFF, 8'h20, 3'd0, 9, 8'h00);
    run_op("sra_sat", 3'b111, 8'h80, 8'h09, 3'd1, 9, 8'hFF);
    run_op("sll3", 3'b110, 8'h13, 8'h03, 3'd2, 4, 8'h98);
    run_op("fwd", 3'b000, 8'h11, 8'h5A, 3'd3, 1, 8'h5A);
    run_op("and", 3'b010, 8'hF0, 8'h3C, 3'd4, 1, 8'h30);
    run_op("or", 3'b011, 8'hF0, 8'h0C, 3'd5, 1, 8'hFC);
    run_op("add_wrap", 3'b001, 8'hFF, 8'h01, 3'd6, 1, 8'h00);

`ifdef ALU_MUL_EN
    issue(3'b101, 8'h0D, 8'h0B, 3'd6);
`else
    issue(3'b110, 8'h01, 8'h08, 3'd6);
`endif
    repeat (3) begin
      @(posedge CLK); #1;
    end
    RESET = 1'b1;
    #1;
    check("abort_busy", BUSY, 1'b0);
    check("abort_result", RESULT, 8'h00);
    check("abort_write", WRITE, 1'b0);
    check("abort_zero", ZERO, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    saw_write = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (WRITE || BUSY) saw_write = 1'b1;
    end
    check("abort_no_write", saw_write, 1'b0);
    run_op("add_after", 3'b001, 8'h01, 8'h02, 3'd5, 1, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
